// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: button-driven front end that loads ALU operands A/B and steps the op select S.
// Ports:
//   clk, rst                      clock, async active-high reset
//   sw[7:0]                       operand switches
//   btn_load, btn_next, btn_auto  raw push-buttons, asynchronous to clk
//   A[7:0], B[7:0]                registered operands
//   S[3:0]                        registered operation select, always < NUM_OPS
//   mode[1:0]                     00 LOAD_A, 01 LOAD_B, 10 RUN, 11 AUTO
//   op_strobe                     one-cycle pulse alongside a new S, or a new B on RUN entry
module alu_op_sequencer #(
    parameter int DB_CYCLES = 500000,
    parameter int DWELL     = 50000000,
    parameter int NUM_OPS   = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       btn_load,
    input  logic       btn_next,
    input  logic       btn_auto,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [3:0] S,
    output logic [1:0] mode,
    output logic       op_strobe
);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int DWW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {LOAD_A = 2'b00, LOAD_B = 2'b01, RUN = 2'b10, AUTO = 2'b11} state_t;

    logic [2:0] w_raw;
    logic [2:0] w_press;
    assign w_raw = {btn_auto, btn_next, btn_load};

    genvar g;
    for (g = 0; g < 3; g++) begin : g_btn
        logic           r_s1, r_s2, r_db, r_pr;
        logic [DBW-1:0] r_cnt;
        // A level change is accepted on the DB_CYCLES-th consecutive differing sample;
        // only the accepted rising edge produces a press.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s1  <= 1'b0;
                r_s2  <= 1'b0;
                r_db  <= 1'b0;
                r_pr  <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_s1 <= w_raw[g];
                r_s2 <= r_s1;
                r_pr <= 1'b0;
                if (r_s2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == DBW'(DB_CYCLES - 1)) begin
                    r_db  <= r_s2;
                    r_cnt <= '0;
                    r_pr  <= r_s2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
        assign w_press[g] = r_pr;
    end

    // Priority load > auto > next; losers are dropped.
    logic w_load, w_auto, w_next;
    assign w_load = w_press[0];
    assign w_auto = w_press[2] & ~w_press[0];
    assign w_next = w_press[1] & ~w_press[2] & ~w_press[0];

    state_t         r_state, w_state;
    logic [7:0]     r_a, r_b, w_a, w_b;
    logic [3:0]     r_s, w_s, w_s_inc;
    logic           r_strobe, w_strobe;
    logic [DWW-1:0] r_dwell, w_dwell;

    assign w_s_inc = (r_s == 4'(NUM_OPS - 1)) ? 4'd0 : r_s + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= LOAD_A;
            r_a      <= '0;
            r_b      <= '0;
            r_s      <= '0;
            r_strobe <= 1'b0;
            r_dwell  <= '0;
        end else begin
            r_state  <= w_state;
            r_a      <= w_a;
            r_b      <= w_b;
            r_s      <= w_s;
            r_strobe <= w_strobe;
            r_dwell  <= w_dwell;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_a      = r_a;
        w_b      = r_b;
        w_s      = r_s;
        w_strobe = 1'b0;
        w_dwell  = r_dwell;
        case (r_state)
            LOAD_A: begin
                if (w_load) begin
                    w_a     = sw;
                    w_state = LOAD_B;
                end
            end
            LOAD_B: begin
                if (w_load) begin
                    w_b      = sw;
                    w_state  = RUN;
                    w_strobe = 1'b1;
                end
            end
            RUN: begin
                if (w_load) begin
                    w_state = LOAD_A;
                end else if (w_auto) begin
                    w_state = AUTO;
                    w_dwell = '0;
                end else if (w_next) begin
                    w_s      = w_s_inc;
                    w_strobe = 1'b1;
                end
            end
            AUTO: begin
                // A press on the terminal dwell cycle suppresses that step.
                if (w_load) begin
                    w_state = LOAD_A;
                end else if (w_auto) begin
                    w_state = RUN;
                end else if (r_dwell == DWW'(DWELL - 1)) begin
                    w_s      = w_s_inc;
                    w_strobe = 1'b1;
                    w_dwell  = '0;
                end else begin
                    w_dwell = r_dwell + 1'b1;
                end
            end
        endcase
    end

    assign A         = r_a;
    assign B         = r_b;
    assign S         = r_s;
    assign mode      = r_state;
    assign op_strobe = r_strobe;
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Front-end controller for the board-level 8-bit ALU. Turns three raw push-buttons and the 8 operand switches into registered operands A and B and the 4-bit operation select S that drives the ALU output multiplexer. It supports manual stepping through operations and an auto-demo mode that cycles S on a fixed dwell. It sits between the board I/O and the ALU function units plus the output mux.

## Interface
Parameters:
- DB_CYCLES, 500000: consecutive stable samples required to accept a button level change (≥2).
- DWELL, 50000000: clock cycles per operation in AUTO mode (≥2).
- NUM_OPS, 13: number of valid select codes; S ranges 0..NUM_OPS-1 (covers 0000..1100, night rider last).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- sw  in  8  operand switches.
- btn_load  in  1  raw load button, active-high, asynchronous to clk.
- btn_next  in  1  raw next-op button, active-high, asynchronous to clk.
- btn_auto  in  1  raw auto-mode toggle button, active-high, asynchronous to clk.
- A  out  8  registered operand A to the ALU.
- B  out  8  registered operand B to the ALU.
- S  out  4  registered operation select to the output mux.
- mode  out  2  FSM state: 00 LOAD_A, 01 LOAD_B, 10 RUN, 11 AUTO.
- op_strobe  out  1  one-cycle pulse when S changes or RUN is entered from LOAD_B.

## Operation
- Each button has its own conditioner: 2-flop synchronizer, then a filter counter. The counter increments while the synchronized value differs from the debounced level, and clears when they match. When DB_CYCLES differing samples have been counted, the debounced level takes the new value and the counter clears. A registered press pulse fires for one cycle on a debounced 0→1 transition only. Releases generate no event.
- FSM, acting on press pulses:
  - LOAD_A: load press → A<=sw, go LOAD_B.
  - LOAD_B: load press → B<=sw, go RUN, op_strobe=1.
  - RUN: next press → S<=S+1 (wraps NUM_OPS-1→0), op_strobe=1. Auto press → go AUTO, clear dwell counter. Load press → go LOAD_A; A, B and S are kept.
  - AUTO: the dwell counter counts clocks. At count DWELL-1: S<=S+1 with wrap, op_strobe=1, counter clears. Auto press → RUN with S held. Load press → LOAD_A. Next press is ignored.
- In LOAD_A and LOAD_B, next and auto presses are ignored and S holds.
- Simultaneous presses in the same cycle: load > auto > next; lower-priority presses are dropped.
- In AUTO, a dwell terminal count in the same cycle as a load or auto press: the press wins, S does not step, op_strobe=0.
- The block never produces S ≥ NUM_OPS.

## Timing
- Reset values, applied immediately on rst assertion: A=0, B=0, S=0, mode=00, op_strobe=0. All synchronizers, filter counters, debounced levels and the dwell counter are 0.
- Button latency: raw rise sampled at edge 0 → synchronizer output at edge 1 → debounced level and press at edge 1+DB_CYCLES → FSM outputs update at edge 2+DB_CYCLES.
- Glitch rejection: a raw pulse whose synchronized value lasts fewer than DB_CYCLES cycles produces no press.
- A press cannot repeat until the button has been debounced low and then high again.
- op_strobe is high exactly one cycle, in the same cycle that the new S (or new B on RUN entry) first appears.
- AUTO stepping: the first step occurs DWELL cycles after the edge that entered AUTO. Subsequent steps occur every DWELL cycles.
- Reset mid-operation: all state clears at once. A button held through rst deassertion is seen as a new press DB_CYCLES+2 edges after the first edge following deassertion.

## Test plan
Bench parameters: DB_CYCLES=4, DWELL=8, NUM_OPS=13.
- Reset, sw=0x3C, press load; sw=0x05, press load → A=0x3C, B=0x05, mode=10, op_strobe pulses once, S=0. Each action lands exactly 6 edges after the press is first sampled.
- In RUN, 13 clean next presses → S steps 1..12 then 0, with one op_strobe per step. A 3-cycle raw glitch on btn_next produces no change.
- Press auto at S=11 → mode=11; S=12 after 8 cycles, S=0 after 16. Press auto again → mode=10 with S frozen.
- load, auto and next pressed in the same cycle while in RUN → mode=00, S unchanged, no op_strobe.
- In AUTO, an auto press lands on the dwell terminal cycle → mode=10, S not stepped, op_strobe stays 0.
- Assert rst mid-AUTO while btn_next is held → all outputs 0 immediately; after release, no S change. The held next press only arrives in LOAD_A, where it is ignored.
